// File: rtl/edge_pkg.sv
// Shared types for the multi-channel debounced edge detector.
// Holds the per-channel debounce FSM states and the tick qualification modes.
package edge_pkg;

  typedef enum logic [1:0] {
    ZERO     = 2'b00,
    CHK_ONE  = 2'b01,
    ONE      = 2'b10,
    CHK_ZERO = 2'b11
  } db_state_t;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  // A tick is an accepted edge of a direction the channel's mode cares about.
  function automatic logic qualify_tick(input logic r, input logic f, input edge_mode_t m);
    return (r & ((m == EM_RISE) || (m == EM_BOTH))) |
           (f & ((m == EM_FALL) || (m == EM_BOTH)));
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, debounce FSM with run counter, Mealy edge pulses,
// mode-qualified tick and a sticky pending flag with level-sensitive clear.
module edge_det_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       filt,
  output logic       rise,
  output logic       fall,
  output logic       tick,
  output logic       pending
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          DB_SINGLE = (DB_CYCLES == 1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_t              r_state;
  db_state_t              w_state_next;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_next;
  logic                   r_pending;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= level;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ZERO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The CHK_* states count consecutive samples at the candidate level;
  // any sample back at the current level abandons the candidate.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ZERO: begin
        if (w_s) begin
          if (DB_SINGLE) begin
            w_state_next = ONE;
            w_cnt_next   = '0;
          end else begin
            w_state_next = CHK_ONE;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      CHK_ONE: begin
        if (!w_s) begin
          w_state_next = ZERO;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ONE: begin
        if (!w_s) begin
          if (DB_SINGLE) begin
            w_state_next = ZERO;
            w_cnt_next   = '0;
          end else begin
            w_state_next = CHK_ZERO;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      CHK_ZERO: begin
        if (w_s) begin
          w_state_next = ONE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ZERO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = ZERO;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Edge pulses come only from registered state and registered s.
  always_comb begin
    w_rise = 1'b0;
    w_fall = 1'b0;
    case (r_state)
      ZERO:     w_rise = w_s & DB_SINGLE;
      CHK_ONE:  w_rise = w_s & (r_cnt == CNT_LAST);
      ONE:      w_fall = ~w_s & DB_SINGLE;
      CHK_ZERO: w_fall = ~w_s & (r_cnt == CNT_LAST);
      default: begin
        w_rise = 1'b0;
        w_fall = 1'b0;
      end
    endcase
  end

  assign w_tick = qualify_tick(w_rise, w_fall, mode);

  // Set has priority over clear so an event arriving with clr is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~clr) | w_tick;
    end
  end

  assign rise    = w_rise & ~rst;
  assign fall    = w_fall & ~rst;
  assign tick    = w_tick & ~rst;
  assign filt    = ~rst & ((r_state == ONE) || (r_state == CHK_ZERO));
  assign pending = r_pending & ~rst;

endmodule

// File: rtl/edge_det_multi.sv
// N_CH independent debounced edge detectors; this level only slices the
// per-channel mode field and replicates the channel.
module edge_det_multi
  import edge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   level,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   filt,
  output logic [N_CH-1:0]   rise,
  output logic [N_CH-1:0]   fall,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending
);

  edge_mode_t w_mode [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign w_mode[gi] = edge_mode_t'(mode[2*gi +: 2]);

    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .level   (level[gi]),
      .mode    (w_mode[gi]),
      .clr     (clr[gi]),
      .filt    (filt[gi]),
      .rise    (rise[gi]),
      .fall    (fall[gi]),
      .tick    (tick[gi]),
      .pending (pending[gi])
    );
  end

endmodule

// File: tb/tb_edge_det_multi.sv
// Bench for edge_det_multi: run-length reference model checked every cycle,
// table-driven scenario checks and a randomized soak.
module tb_edge_det_multi;

  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int DB   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   level;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   filt, rise, fall, tick, pending;

  edge_det_multi #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .level   (level),
    .mode    (mode),
    .clr     (clr),
    .filt    (filt),
    .rise    (rise),
    .fall    (fall),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Inputs to apply after the next edge.
  logic              nx_rst;
  logic [N_CH-1:0]   nx_level;
  logic [2*N_CH-1:0] nx_mode;
  logic [N_CH-1:0]   nx_clr;

  // Reference model: s is the input delayed SYNC edges; an edge is accepted
  // once s has held a value opposite to the debounced level for DB cycles.
  logic [SYNC-1:0] m_pipe [N_CH];
  int              m_run  [N_CH];
  logic [N_CH-1:0] m_filt, m_pend, m_rise, m_fall, m_tick, m_filt_o, m_pend_o;

  int cnt_rise [N_CH];
  int cnt_fall [N_CH];
  int cnt_tick [N_CH];
  int cnt_filt [N_CH];

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) begin
      cnt_rise[c] = 0; cnt_fall[c] = 0; cnt_tick[c] = 0; cnt_filt[c] = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        m_pipe[c] = '0;
        m_run[c]  = 1;
      end
      m_filt = '0;
      m_pend = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        logic old_s;
        m_pend[c] = (m_pend[c] & ~clr[c]) | m_tick[c];
        if (m_rise[c]) m_filt[c] = 1'b1;
        if (m_fall[c]) m_filt[c] = 1'b0;
        old_s = m_pipe[c][SYNC-1];
        m_pipe[c] = {m_pipe[c][SYNC-2:0], level[c]};
        if (m_pipe[c][SYNC-1] == old_s) begin
          if (m_run[c] < 1000) m_run[c]++;
        end else begin
          m_run[c] = 1;
        end
      end
    end
  endtask

  task automatic model_out();
    for (int c = 0; c < N_CH; c++) begin
      logic s;
      s = m_pipe[c][SYNC-1];
      m_rise[c]   = !rst && !m_filt[c] && s && (m_run[c] >= DB);
      m_fall[c]   = !rst && m_filt[c] && !s && (m_run[c] >= DB);
      m_tick[c]   = (m_rise[c] & mode[2*c]) | (m_fall[c] & mode[2*c+1]);
      m_filt_o[c] = !rst & m_filt[c];
      m_pend_o[c] = !rst & m_pend[c];
    end
  endtask

  // One clock: edge, model update, apply next inputs, compare with the model.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    rst = nx_rst; level = nx_level; mode = nx_mode; clr = nx_clr;
    #1;
    model_out();
    n_vec++;
    if ({rise, fall, tick, filt, pending} !== {m_rise, m_fall, m_tick, m_filt_o, m_pend_o}) begin
      n_err++;
      $display("FAIL cycle_vs_model t=%0t: rise=%b fall=%b tick=%b filt=%b pend=%b, expected rise=%b fall=%b tick=%b filt=%b pend=%b",
               $time, rise, fall, tick, filt, pending, m_rise, m_fall, m_tick, m_filt_o, m_pend_o);
    end
    for (int c = 0; c < N_CH; c++) begin
      cnt_rise[c] += int'(rise[c]);
      cnt_fall[c] += int'(fall[c]);
      cnt_tick[c] += int'(tick[c]);
      cnt_filt[c] += int'(filt[c]);
    end
  endtask

  typedef struct {
    int len;
    int exp_rise;
    int exp_fall;
  } glitch_vec_t;

  typedef struct {
    logic [1:0] md;
    int         exp_tick;
    int         exp_rise;
    int         exp_fall;
  } mode_vec_t;

  glitch_vec_t gtab [4];
  mode_vec_t   mtab [4];

  initial begin
    int first_rise;
    int full_cnt;
    int part_cnt;
    int hold [N_CH];
    int total_rise;

    gtab[0] = '{len: 1, exp_rise: 0, exp_fall: 0};
    gtab[1] = '{len: 2, exp_rise: 0, exp_fall: 0};
    gtab[2] = '{len: 3, exp_rise: 1, exp_fall: 1};
    gtab[3] = '{len: 6, exp_rise: 1, exp_fall: 1};
    mtab[0] = '{md: 2'b00, exp_tick: 0, exp_rise: 1, exp_fall: 1};
    mtab[1] = '{md: 2'b01, exp_tick: 1, exp_rise: 1, exp_fall: 1};
    mtab[2] = '{md: 2'b10, exp_tick: 1, exp_rise: 1, exp_fall: 1};
    mtab[3] = '{md: 2'b11, exp_tick: 2, exp_rise: 1, exp_fall: 1};

    rst = 1'b1; level = '0; mode = '0; clr = '0;
    nx_rst = 1'b1; nx_level = '0; nx_mode = '0; nx_clr = '0;
    m_filt = '0; m_pend = '0; m_rise = '0; m_fall = '0; m_tick = '0;
    m_filt_o = '0; m_pend_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_pipe[c] = '0;
      m_run[c]  = 1;
    end
    clear_counts();

    repeat (3) step();
    check("reset_outputs_zero", int'({rise, fall, tick, filt, pending}), 0);
    nx_rst = 1'b0;
    repeat (5) step();
    check("post_reset_outputs_zero", int'({rise, fall, tick, filt, pending}), 0);

    // Clean rising step on channel 0; step 1 is the capture edge.
    nx_mode = 8'h55;
    repeat (2) step();
    clear_counts();
    first_rise = -1;
    nx_level = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rise[0] && first_rise < 0) first_rise = i;
      if (i == 4) begin
        check("clean_tick_with_rise", int'(tick[0]), 1);
        check("clean_filt_not_yet", int'(filt[0]), 0);
      end
      if (i == 5) begin
        check("clean_filt_set", int'(filt[0]), 1);
        check("clean_pending_set", int'(pending[0]), 1);
      end
    end
    check("clean_rise_cycle", first_rise, 4);
    check("clean_rise_count", cnt_rise[0], 1);
    check("clean_other_channels_quiet", cnt_rise[1] + cnt_rise[2] + cnt_rise[3], 0);

    // Glitch rejection on channel 1.
    for (int v = 0; v < 4; v++) begin
      clear_counts();
      nx_level[1] = 1'b1;
      repeat (gtab[v].len) step();
      nx_level[1] = 1'b0;
      repeat (12) step();
      check($sformatf("glitch_len%0d_rise", gtab[v].len), cnt_rise[1], gtab[v].exp_rise);
      check($sformatf("glitch_len%0d_fall", gtab[v].len), cnt_fall[1], gtab[v].exp_fall);
      check($sformatf("glitch_len%0d_filt_seen", gtab[v].len), int'(cnt_filt[1] > 0), gtab[v].exp_rise);
    end

    // Mode coverage on channel 2.
    for (int v = 0; v < 4; v++) begin
      clear_counts();
      nx_mode[5:4] = mtab[v].md;
      nx_level[2] = 1'b1;
      repeat (10) step();
      nx_level[2] = 1'b0;
      repeat (10) step();
      check($sformatf("mode%0b_tick", mtab[v].md), cnt_tick[2], mtab[v].exp_tick);
      check($sformatf("mode%0b_rise", mtab[v].md), cnt_rise[2], mtab[v].exp_rise);
      check($sformatf("mode%0b_fall", mtab[v].md), cnt_fall[2], mtab[v].exp_fall);
    end

    // Pending set/clear race on channel 3 (tick lands on step 4).
    nx_mode[7:6] = 2'b01;
    nx_level[3] = 1'b1;
    step();
    repeat (3) step();
    nx_clr[3] = 1'b1;
    step();
    check("race_tick_present", int'(tick[3]), 1);
    step();
    check("race_pending_set_wins", int'(pending[3]), 1);
    nx_clr[3] = 1'b0;
    step();
    check("clr_next_edge", int'(pending[3]), 0);

    // Reset in the middle of a debounce on channel 0.
    nx_level[0] = 1'b0;
    repeat (10) step();
    clear_counts();
    first_rise = -1;
    nx_level[0] = 1'b1;
    step();
    step();
    nx_rst = 1'b1;
    step();
    check("mid_rst_outputs_zero", int'({rise, fall, tick, filt, pending}), 0);
    check("mid_rst_no_early_rise", cnt_rise[0], 0);
    nx_rst = 1'b0;
    for (int i = 3; i < 13; i++) begin
      step();
      if (rise[0] && first_rise < 0) first_rise = i;
    end
    check("mid_rst_rise_cycle", first_rise, 7);
    check("mid_rst_rise_count", cnt_rise[0], 1);

    // All channels step together, mode both.
    nx_mode = 8'hFF;
    nx_level = '0;
    repeat (12) step();
    for (int ph = 0; ph < 2; ph++) begin
      full_cnt = 0;
      part_cnt = 0;
      nx_level = (ph == 0) ? 4'hF : 4'h0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (tick == 4'hF) full_cnt++;
        else if (tick != 4'h0) part_cnt++;
      end
      check($sformatf("simul_ph%0d_full_tick", ph), full_cnt, 1);
      check($sformatf("simul_ph%0d_partial_tick", ph), part_cnt, 0);
      check($sformatf("simul_ph%0d_filt", ph), int'(filt), (ph == 0) ? 15 : 0);
    end

    // Randomized soak against the model.
    clear_counts();
    for (int c = 0; c < N_CH; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hold[c] == 0) begin
          nx_level[c] = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 7));
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 15) == 0) nx_mode = 8'($urandom);
      nx_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      nx_rst = ($urandom_range(0, 199) == 0);
      step();
    end
    nx_rst = 1'b0;
    nx_clr = '0;
    repeat (10) step();
    total_rise = 0;
    for (int c = 0; c < N_CH; c++) total_rise += cnt_rise[c];
    check("random_activity", int'(total_rise > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
